// File: rtl/trig_bank.sv
// trig_bank: N-channel RS/JK/D/T master-slave trigger bank with edge pulses.
// Define TRIG_ERR_EN to build the sticky illegal-RS-input flags.
module trig_bank #(
    parameter int           N          = 4,
    parameter logic [N-1:0] INIT       = '0,
    parameter int           RS_ILLEGAL = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic [2*N-1:0] mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [N-1:0]   Y,
    output logic [N-1:0]   Q,
    output logic [N-1:0]   Qn,
    output logic [N-1:0]   rise,
    output logic [N-1:0]   fall,
    output logic [N-1:0]   err,
    input  logic           err_clr
);
    logic [N-1:0] y_q, y_d, q_q, rise_q, fall_q;

    // Next master state for one channel; y is the present master state.
    function automatic logic next_bit(input logic [1:0] m, input logic s, input logic r, input logic y);
        logic rs_ill;
        rs_ill = (RS_ILLEGAL == 1) ? 1'b1 :
                 (RS_ILLEGAL == 2) ? 1'b0 :
                 (RS_ILLEGAL == 3) ? ~y : y;
        return (m == 2'b00) ? ((s & r) ? rs_ill : s ? 1'b1 : r ? 1'b0 : y) :
               (m == 2'b01) ? ((s & r) ? ~y : s ? 1'b1 : r ? 1'b0 : y) :
               (m == 2'b10) ? s :
               (s ? ~y : y);
    endfunction

    always_comb begin
        y_d = y_q;
        for (int i = 0; i < N; i++)
            if (ce) y_d[i] = next_bit(mode[2*i +: 2], a[i], b[i], y_q[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q    <= INIT;
            q_q    <= INIT;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            y_q    <= y_d;
            q_q    <= y_q;
            rise_q <= y_q & ~q_q;
            fall_q <= ~y_q & q_q;
        end
    end

`ifdef TRIG_ERR_EN
    logic [N-1:0] err_q, err_d, ill;

    always_comb begin
        ill = '0;
        for (int i = 0; i < N; i++)
            ill[i] = ce & (mode[2*i +: 2] == 2'b00) & a[i] & b[i];
        err_d = (err_clr ? '0 : err_q) | ill;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err = '0;
`endif

    assign Y    = y_q;
    assign Q    = q_q;
    assign Qn   = ~q_q;
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: tb/tb_trig_bank.sv
// tb_trig_bank: directed self-checking bench for trig_bank (N=4, INIT=1010, RS_ILLEGAL=3).
module tb_trig_bank;
    logic       clk = 0;
    logic       rst, ce, err_clr;
    logic [7:0] mode;
    logic [3:0] a, b;
    logic [3:0] Y, Q, Qn, rise, fall, err;
    int total = 0;
    int bad = 0;

`ifdef TRIG_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    trig_bank #(.N(4), .INIT(4'b1010), .RS_ILLEGAL(3)) dut (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .a(a), .b(b),
        .Y(Y), .Q(Q), .Qn(Qn), .rise(rise), .fall(fall), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [15:0] got;
        rst = 1; ce = 0; a = 0; b = 0; mode = 0; err_clr = 0;
        tick(2);
        got = {Y, Q, rise, fall};
        total++; if (got !== 16'b1010_1010_0000_0000) begin bad++; $display("FAIL reset_state got=%b exp=%b", got, 16'b1010_1010_0000_0000); end
        total++; if (Qn !== 4'b0101) begin bad++; $display("FAIL reset_qn got=%b exp=%b", Qn, 4'b0101); end
        total++; if (err !== 4'b0000) begin bad++; $display("FAIL reset_err got=%b exp=%b", err, 4'b0000); end
        rst = 0; ce = 1;
        tick(3);
        got = {Y, Q, rise, fall};
        total++; if (got !== 16'b1010_1010_0000_0000) begin bad++; $display("FAIL reset_hold got=%b exp=%b", got, 16'b1010_1010_0000_0000); end
    endtask

    task automatic test_rs;
        logic [15:0] exp [7] = '{16'b1011_1010_0000_0000, 16'b1011_1011_0001_0000, 16'b1011_1011_0000_0000,
                                 16'b1011_1011_0000_0000, 16'b1010_1011_0000_0000, 16'b1010_1010_0000_0001,
                                 16'b1010_1010_0000_0000};
        logic [3:0]  av  [7] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0]  bv  [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        logic [15:0] got;
        mode = 0; ce = 1;
        for (int i = 0; i < 7; i++) begin
            a = av[i]; b = bv[i];
            tick(1);
            got = {Y, Q, rise, fall};
            total++; if (got !== exp[i]) begin bad++; $display("FAIL rs_step%0d got=%b exp=%b", i, got, exp[i]); end
        end
    endtask

    task automatic test_illegal;
        logic [15:0] exp [5] = '{16'b1011_1010_0000_0000, 16'b1010_1011_0001_0000, 16'b1011_1010_0000_0001,
                                 16'b1010_1011_0001_0000, 16'b1010_1010_0000_0001};
        logic [3:0]  ee  [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        logic [15:0] got;
        logic [3:0]  ex;
        mode = 0; ce = 1;
        for (int i = 0; i < 5; i++) begin
            a = (i < 4) ? 4'b0001 : 4'b0000;
            b = a;
            err_clr = (i >= 3);
            tick(1);
            got = {Y, Q, rise, fall};
            ex = ERR_ON ? ee[i] : 4'b0000;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL illegal_step%0d got=%b exp=%b", i, got, exp[i]); end
            total++; if (err !== ex) begin bad++; $display("FAIL illegal_err%0d got=%b exp=%b", i, err, ex); end
        end
        err_clr = 0;
    endtask

    task automatic test_t_mode;
        logic [15:0] exp [5] = '{16'b1010_1000_0000_0000, 16'b1010_1010_0010_0000, 16'b1000_1010_0000_0000,
                                 16'b1010_1000_0000_0010, 16'b1010_1010_0010_0000};
        logic        cev [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] got;
        mode = 0; ce = 1; a = 0; b = 4'b0010;
        tick(1);
        b = 0;
        tick(2);
        got = {Y, Q, rise, fall};
        total++; if (got !== 16'b1000_1000_0000_0000) begin bad++; $display("FAIL t_setup got=%b exp=%b", got, 16'b1000_1000_0000_0000); end
        mode = 8'b00_00_11_00;
        for (int i = 0; i < 5; i++) begin
            ce = cev[i];
            a  = (i < 4) ? 4'b0010 : 4'b0000;
            tick(1);
            got = {Y, Q, rise, fall};
            total++; if (got !== exp[i]) begin bad++; $display("FAIL t_step%0d got=%b exp=%b", i, got, exp[i]); end
        end
    endtask

    task automatic test_mix;
        logic [15:0] exp [3] = '{16'b0101_1010_0000_0000, 16'b1011_0101_0101_1010, 16'b0110_1011_1010_0100};
        logic [3:0]  av  [3] = '{4'b0101, 4'b1010, 4'b0101};
        logic [3:0]  bv  [3] = '{4'b0110, 4'b1101, 4'b0000};
        logic [15:0] got;
        mode = 8'b10_01_00_11; ce = 1;
        for (int i = 0; i < 3; i++) begin
            a = av[i]; b = bv[i];
            tick(1);
            got = {Y, Q, rise, fall};
            total++; if (got !== exp[i]) begin bad++; $display("FAIL mix_step%0d got=%b exp=%b", i, got, exp[i]); end
        end
        total++; if (err !== 4'b0000) begin bad++; $display("FAIL mix_err got=%b exp=%b", err, 4'b0000); end
    endtask

    task automatic test_ce_off;
        logic [15:0] got;
        ce = 0; mode = 8'hAA; a = 4'b1111; b = 4'b0000;
        tick(1);
        got = {Y, Q, rise, fall};
        total++; if (got !== 16'b0110_0110_0100_1001) begin bad++; $display("FAIL ceoff_1 got=%b exp=%b", got, 16'b0110_0110_0100_1001); end
        tick(1);
        got = {Y, Q, rise, fall};
        total++; if (got !== 16'b0110_0110_0000_0000) begin bad++; $display("FAIL ceoff_2 got=%b exp=%b", got, 16'b0110_0110_0000_0000); end
    endtask

    task automatic test_rst_mid;
        logic [15:0] got;
        mode = 0; ce = 1; a = 4'b0001; b = 0;
        tick(1);
        got = {Y, Q, rise, fall};
        total++; if (got !== 16'b0111_0110_0000_0000) begin bad++; $display("FAIL rstmid_pending got=%b exp=%b", got, 16'b0111_0110_0000_0000); end
        rst = 1; a = 0;
        tick(1);
        got = {Y, Q, rise, fall};
        total++; if (got !== 16'b1010_1010_0000_0000) begin bad++; $display("FAIL rstmid_reset got=%b exp=%b", got, 16'b1010_1010_0000_0000); end
        rst = 0; ce = 0;
        tick(1);
        got = {Y, Q, rise, fall};
        total++; if (got !== 16'b1010_1010_0000_0000) begin bad++; $display("FAIL rstmid_after got=%b exp=%b", got, 16'b1010_1010_0000_0000); end
        total++; if (Qn !== 4'b0101) begin bad++; $display("FAIL rstmid_qn got=%b exp=%b", Qn, 4'b0101); end
    endtask

    initial begin
        test_reset;
        test_rs;
        test_illegal;
        test_t_mode;
        test_mix;
        test_ce_off;
        test_rst_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trig_bank.md
Name: trig_bank

Overview:
- Parametrised N-channel clocked trigger bank; successor to the single RS_Trig block.
- Each channel is runtime-selectable as an RS, JK, D or T flip-flop.
- Each channel has a master/slave two-stage structure with Y/Q/Qn outputs, edge-pulse outputs and a policy for the illegal RS input.
- Used as the generic storage/toggle primitive for game-logic control flags.

Parameters:
N, 4, number of independent channels (1..32)
INIT, 0, N-bit reset value loaded into Y and Q
RS_ILLEGAL, 0, RS-mode response to S=R=1: 0 hold, 1 set, 2 reset, 3 toggle

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
ce  in  1  clock enable; master stage updates only when ce=1
mode  in  2*N  per-channel mode, channel i at bits [2i+1:2i]: 00 RS, 01 JK, 10 D, 11 T
a  in  N  per-channel first input: S / J / D / T
b  in  N  per-channel second input: R / K; ignored in D and T modes
Y  out  N  master-stage state (registered)
Q  out  N  slave-stage state (registered)
Qn  out  N  ~Q (combinational)
rise  out  N  one-cycle pulse, high in the first cycle Q reads 1 after reading 0
fall  out  N  one-cycle pulse, high in the first cycle Q reads 0 after reading 1
err  out  N  sticky illegal-input flag (see Optional Feature)
err_clr  in  1  clears all err bits

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high (rst sampled on rising clk edge; rst has priority over everything).
- Reset values:
  - Y=INIT, Q=INIT, rise=0, fall=0, err=0.
  - Qn=~INIT.
- Master stage, per channel i, on an edge with ce=1. Present state is Y[i], not Q[i], so back-to-back ce cycles behave correctly.
  - RS (00): a=1,b=0 → Y=1; a=0,b=1 → Y=0; a=0,b=0 → hold; a=1,b=1 → RS_ILLEGAL policy.
  - JK (01): J=1,K=0 → 1; J=0,K=1 → 0; 00 → hold; 11 → Y=~Y.
  - D (10): Y=a.
  - T (11): a=1 → Y=~Y; a=0 → hold.
- ce=0: Y holds for all channels regardless of a/b/mode.
- Slave stage: Q<=Y on every edge, independent of ce.
  - Latency: inputs sampled at edge k with ce=1 give Y valid after edge k and Q valid after edge k+1.
- Edge pulses: at the same edge Q loads Y:
  - rise<=Y&~Q
  - fall<=~Y&Q
  - Pulses are exactly one cycle unless Q changes again on the next edge.
- Mode changes:
  - Mode is sampled only on ce edges.
  - A mode change preserves Y/Q; the new mode applies from that edge.
- Channel independence: no cross-channel interaction; all N channels update in parallel.
- Reset mid-operation: a pending Y→Q transfer is discarded; Q=INIT on the edge after rst=1, and no rise/fall pulse is generated by the reset itself.

Optional Feature:
Macro TRIG_ERR_EN.
- Defined:
  - err[i] sets on an edge with ce=1, mode[i]=RS and a[i]=b[i]=1.
  - err[i] holds until err_clr=1 or rst.
  - Set and err_clr on the same edge: set wins (err=1).
- Undefined: err is tied to 0, err_clr is ignored, and no err registers are built.

Test Plan:
- Reset: rst=1 for 2 cycles with N=4, INIT=4'b1010 → Y=Q=1010, Qn=0101, rise=fall=0; ce=1, a=b=0 in RS mode afterwards holds 1010.
- RS ch0: S=1,R=0 at edge k → Y[0]=1 after k, Q[0]=1 and rise[0]=1 for one cycle after k+1; hold 3 cycles → unchanged; R=1 → Q[0]=0 two edges later with fall[0] pulse.
- Illegal RS: RS_ILLEGAL=3, S=R=1 for 4 ce cycles from Y=0 → Y sequence 1,0,1,0; Q lags one cycle; with TRIG_ERR_EN err[0]=1 sticky; err_clr together with S=R=1 → err stays 1; err_clr alone → 0.
- T mode ch1: a=1, ce toggled 1,0,1,1 from Y=0 → Y=1,1,0,1; each Q change gives a one-cycle rise/fall.
- JK/D mix: mode=8'b10_01_00_11, per-channel patterns applied simultaneously → each channel matches its own truth table, no cross-talk.
- Reset mid-operation: Y=1,Q=0 (transfer pending) and rst=1 → Q=INIT next edge, no rise pulse.
